// File: rtl/frogger_game_ctrl.sv
// Game sequencer for the frogger datapath: tracks level, lives and score and
// drives the car/frog mover resets through play, death, level-up and game-over.
module frogger_game_ctrl #(
  parameter int unsigned START_LIVES    = 3,
  parameter logic [3:0]  MAX_LEVEL      = 4'd9,
  parameter logic [13:0] SCORE_PER_GOAL = 14'd100,
  parameter logic [13:0] SCORE_MAX      = 14'd9999,
  parameter logic [23:0] PAUSE_CYCLES   = 24'd12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frog_hit,
  input  logic        frog_goal,
  output logic [3:0]  level,
  output logic [2:0]  lives,
  output logic [13:0] score,
  output logic        cars_reset,
  output logic        frog_reset,
  output logic        game_over,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DEATH     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
  localparam logic [23:0] PAUSE_LAST = PAUSE_CYCLES - 24'd1;

  state_e      state_q, state_d;
  logic [23:0] pause_q, pause_d;
  logic [3:0]  level_q, level_d;
  logic [2:0]  lives_q, lives_d;
  logic [13:0] score_q, score_d;
  logic        cars_reset_q, cars_reset_d;
  logic        frog_reset_q, frog_reset_d;
  logic        game_over_q, game_over_d;
  logic [14:0] score_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pause_q      <= '0;
      level_q      <= 4'd1;
      lives_q      <= LIVES_INIT;
      score_q      <= '0;
      cars_reset_q <= 1'b1;
      frog_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pause_q      <= pause_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      cars_reset_q <= cars_reset_d;
      frog_reset_q <= frog_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  // Score sum is one bit wider so the saturation compare cannot be fooled by wrap.
  assign score_sum = {1'b0, score_q} + {1'b0, SCORE_PER_GOAL};

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    score_d = score_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PLAY;
      S_PLAY: begin
        if (frog_hit) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = S_DEATH;
          end else begin
            lives_d = 3'd0;
            state_d = S_GAME_OVER;
          end
        end else if (frog_goal) begin
          score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
          level_d = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 4'd1;
          state_d = S_LEVEL_UP;
        end
      end
      S_DEATH, S_LEVEL_UP: if (pause_q == PAUSE_LAST) state_d = S_PLAY;
      S_GAME_OVER: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Entering IDLE reloads a fresh game so level can never read 0.
    if (state_d == S_IDLE) begin
      level_d = 4'd1;
      lives_d = LIVES_INIT;
      score_d = '0;
    end
    if ((state_d == state_q) && ((state_q == S_DEATH) || (state_q == S_LEVEL_UP)))
      pause_d = pause_q + 24'd1;
    else
      pause_d = '0;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cars_reset_d = 1'b1;
    frog_reset_d = 1'b1;
    game_over_d  = 1'b0;
    case (state_d)
      S_PLAY: begin
        cars_reset_d = 1'b0;
        frog_reset_d = 1'b0;
      end
      S_DEATH:     cars_reset_d = 1'b0;
      S_GAME_OVER: game_over_d  = 1'b1;
      default: ;
    endcase
  end

  assign level      = level_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign cars_reset = cars_reset_q;
  assign frog_reset = frog_reset_q;
  assign game_over  = game_over_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Scoreboard bench for frogger_game_ctrl: each stimulus cycle queues the
// hand-computed outputs expected after that edge; a monitor pops and compares.
module tb_frogger_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        frog_hit = 1'b0;
  logic        frog_goal = 1'b0;
  logic [3:0]  level;
  logic [2:0]  lives;
  logic [13:0] score;
  logic        cars_reset;
  logic        frog_reset;
  logic        game_over;
  logic [2:0]  state_o;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  lvl;
    logic [2:0]  lv;
    logic [13:0] sc;
    logic        cr;
    logic        fr;
    logic        go;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  frogger_game_ctrl #(
    .START_LIVES   (3),
    .MAX_LEVEL     (4'd3),
    .SCORE_PER_GOAL(14'd100),
    .SCORE_MAX     (14'd250),
    .PAUSE_CYCLES  (24'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .frog_hit  (frog_hit),
    .frog_goal (frog_goal),
    .level     (level),
    .lives     (lives),
    .score     (score),
    .cars_reset(cars_reset),
    .frog_reset(frog_reset),
    .game_over (game_over),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [3:0] lvl,
                              input logic [2:0] lv, input logic [13:0] sc,
                              input logic cr, input logic fr, input logic go);
    mk = '{st: st, lvl: lvl, lv: lv, sc: sc, cr: cr, fr: fr, go: go};
  endfunction

  task automatic chk(input string name, input int v, input logic [13:0] act, input logic [13:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL vec%0d %s: got %0d expected %0d", v, name, act, req);
    end
  endtask

  // Monitor: one expected entry per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("state_o",    vectors, 14'(state_o),    14'(e.st));
        chk("level",      vectors, 14'(level),      14'(e.lvl));
        chk("lives",      vectors, 14'(lives),      14'(e.lv));
        chk("score",      vectors, score,           e.sc);
        chk("cars_reset", vectors, 14'(cars_reset), 14'(e.cr));
        chk("frog_reset", vectors, 14'(frog_reset), 14'(e.fr));
        chk("game_over",  vectors, 14'(game_over),  14'(e.go));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic g,
                               input exp_t e, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = r;
      start     = s;
      frog_hit  = h;
      frog_goal = g;
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  initial begin
    exp_t idle, play;
    idle = mk(3'd0, 4'd1, 3'd3, 14'd0, 1'b1, 1'b1, 1'b0);
    play = mk(3'd1, 4'd1, 3'd3, 14'd0, 1'b0, 1'b0, 1'b0);

    // Reset and start
    applyStimulus(1, 0, 0, 0, idle, 2);
    applyStimulus(0, 0, 1, 1, idle);
    applyStimulus(0, 1, 0, 0, play);
    applyStimulus(0, 1, 0, 0, play);

    // Single death: exactly four DEATH cycles, inputs ignored there
    applyStimulus(0, 0, 1, 0, mk(3'd2, 4'd1, 3'd2, 14'd0, 1'b0, 1'b1, 1'b0));
    applyStimulus(0, 1, 1, 1, mk(3'd2, 4'd1, 3'd2, 14'd0, 1'b0, 1'b1, 1'b0), 3);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd1, 3'd2, 14'd0, 1'b0, 1'b0, 1'b0));

    // Three goals: level saturates at 3, score saturates at 250
    applyStimulus(0, 0, 0, 1, mk(3'd3, 4'd2, 3'd2, 14'd100, 1'b1, 1'b1, 1'b0));
    applyStimulus(0, 0, 1, 1, mk(3'd3, 4'd2, 3'd2, 14'd100, 1'b1, 1'b1, 1'b0), 3);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd2, 3'd2, 14'd100, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, 0, 0, 1, mk(3'd3, 4'd3, 3'd2, 14'd200, 1'b1, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, mk(3'd3, 4'd3, 3'd2, 14'd200, 1'b1, 1'b1, 1'b0), 3);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd3, 3'd2, 14'd200, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, 0, 0, 1, mk(3'd3, 4'd3, 3'd2, 14'd250, 1'b1, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, mk(3'd3, 4'd3, 3'd2, 14'd250, 1'b1, 1'b1, 1'b0), 3);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd3, 3'd2, 14'd250, 1'b0, 1'b0, 1'b0));

    // Hit and goal together: hit wins
    applyStimulus(0, 0, 1, 1, mk(3'd2, 4'd3, 3'd1, 14'd250, 1'b0, 1'b1, 1'b0));
    applyStimulus(0, 0, 0, 0, mk(3'd2, 4'd3, 3'd1, 14'd250, 1'b0, 1'b1, 1'b0), 3);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd3, 3'd1, 14'd250, 1'b0, 1'b0, 1'b0));

    // Last life: game over, further hits ignored, two starts restart
    applyStimulus(0, 0, 1, 0, mk(3'd4, 4'd3, 3'd0, 14'd250, 1'b1, 1'b1, 1'b1));
    applyStimulus(0, 0, 1, 1, mk(3'd4, 4'd3, 3'd0, 14'd250, 1'b1, 1'b1, 1'b1), 2);
    applyStimulus(0, 1, 0, 0, idle);
    applyStimulus(0, 1, 0, 0, play);

    // Reset in the second LEVEL_UP cycle
    applyStimulus(0, 0, 0, 1, mk(3'd3, 4'd2, 3'd3, 14'd100, 1'b1, 1'b1, 1'b0), 2);
    applyStimulus(1, 0, 0, 0, idle);
    applyStimulus(0, 1, 0, 0, play);
    applyStimulus(0, 0, 1, 0, mk(3'd2, 4'd1, 3'd2, 14'd0, 1'b0, 1'b1, 1'b0), 4);
    applyStimulus(0, 0, 0, 0, mk(3'd1, 4'd1, 3'd2, 14'd0, 1'b0, 1'b0, 1'b0));

    begin : drain
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        miscompares++;
        $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
